// File: rtl/sd_dev_data_tx_ctrl_if.sv
// Byte-stream handshake, control and SD data-bus signals of the device-side
// 4-bit data transmit sequencer. master = block-buffer/function side, slave = sequencer.
interface sd_dev_data_tx_ctrl_if;
    logic        i_locked;
    logic        i_start;
    logic [15:0] i_block_count;
    logic        i_abort;
    logic [7:0]  i_data;
    logic        i_data_valid;
    logic        o_data_ready;
    logic        o_sd_data_dir;
    logic [7:0]  o_sd_data_out;
    logic        o_busy;
    logic        o_block_sent;
    logic        o_done;
    logic        o_underflow;

    modport master (
        output i_locked, i_start, i_block_count, i_abort, i_data, i_data_valid,
        input  o_data_ready, o_sd_data_dir, o_sd_data_out, o_busy, o_block_sent,
               o_done, o_underflow
    );

    modport slave (
        input  i_locked, i_start, i_block_count, i_abort, i_data, i_data_valid,
        output o_data_ready, o_sd_data_dir, o_sd_data_out, o_busy, o_block_sent,
               o_done, o_underflow
    );
endinterface

// File: rtl/sd_dev_data_tx_ctrl.sv
// Device-side SD 4-bit data transmit sequencer: frames a byte stream into blocks
// (start nibble, payload, per-line CRC16, end nibble) and drives the PHY direction.
module sd_dev_data_tx_ctrl #(
    parameter int BLOCK_SIZE  = 512,
    parameter int GAP_CYCLES  = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sd_dev_data_tx_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_CRC, S_END, S_GAP, S_TURN
    } state_t;

    localparam logic [15:0] NBYTES    = 16'(BLOCK_SIZE);
    localparam logic [15:0] LAST_BYTE = 16'(BLOCK_SIZE - 1);
    localparam logic [15:0] LAST_GAP  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] LAST_TURN = 16'(TURN_CYCLES - 1);

    state_t           st;
    logic [15:0]      cnt;
    logic [15:0]      remaining;
    logic [3:0][15:0] crc;
    logic             aborted;
    logic             stop;
    logic [7:0]       tx_byte;
    logic [15:0]      next_idx;

    // Serial CRC16-CCITT (x^16+x^12+x^5+1), one bit MSB-first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
    endfunction

    // Each DAT line absorbs its high-nibble bit first, then its low-nibble bit.
    function automatic logic [3:0][15:0] crc_byte(input logic [3:0][15:0] c,
                                                  input logic [7:0] b);
        logic [3:0][15:0] r;
        r[0] = crc_step(crc_step(c[0], b[4]), b[0]);
        r[1] = crc_step(crc_step(c[1], b[5]), b[1]);
        r[2] = crc_step(crc_step(c[2], b[6]), b[2]);
        r[3] = crc_step(crc_step(c[3], b[7]), b[3]);
        return r;
    endfunction

    function automatic logic [7:0] crc_out(input logic [3:0][15:0] c, input logic [2:0] idx);
        logic [3:0][15:0] s;
        s[0] = c[0] << {idx, 1'b0};
        s[1] = c[1] << {idx, 1'b0};
        s[2] = c[2] << {idx, 1'b0};
        s[3] = c[3] << {idx, 1'b0};
        return {s[3][15], s[2][15], s[1][15], s[0][15], s[3][14], s[2][14], s[1][14], s[0][14]};
    endfunction

    assign stop     = bus.i_abort | ~bus.i_locked;
    assign tx_byte  = bus.i_data_valid ? bus.i_data : 8'h00;
    assign next_idx = (st == S_START) ? 16'd0 : cnt + 16'd1;

    // State names describe what is on the wire this cycle; o_data_ready leads the
    // wire by one cycle so the byte accepted now is transmitted in the next slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            st                <= S_IDLE;
            cnt               <= '0;
            remaining         <= '0;
            crc               <= '0;
            aborted           <= 1'b0;
            bus.o_sd_data_dir <= 1'b0;
            bus.o_sd_data_out <= 8'hFF;
            bus.o_data_ready  <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_block_sent  <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_underflow   <= 1'b0;
        end else begin
            bus.o_block_sent <= 1'b0;
            bus.o_done       <= 1'b0;
            bus.o_underflow  <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (bus.i_start && bus.i_locked) begin
                        if (bus.i_block_count != '0) begin
                            st                <= S_START;
                            remaining         <= bus.i_block_count;
                            aborted           <= 1'b0;
                            crc               <= '0;
                            bus.o_busy        <= 1'b1;
                            bus.o_sd_data_dir <= 1'b1;
                            bus.o_sd_data_out <= 8'hF0;
                            bus.o_data_ready  <= 1'b1;
                        end else begin
                            bus.o_done <= 1'b1;
                        end
                    end
                end
                S_START, S_DATA: begin
                    if (stop) begin
                        st                <= S_END;
                        aborted           <= 1'b1;
                        bus.o_sd_data_out <= 8'hFF;
                        bus.o_data_ready  <= 1'b0;
                    end else if (st == S_DATA && cnt == LAST_BYTE) begin
                        st                <= S_CRC;
                        cnt               <= '0;
                        bus.o_sd_data_out <= crc_out(crc, 3'd0);
                        bus.o_data_ready  <= 1'b0;
                    end else begin
                        st                <= S_DATA;
                        cnt               <= next_idx;
                        crc               <= crc_byte(crc, tx_byte);
                        bus.o_sd_data_out <= tx_byte;
                        bus.o_underflow   <= ~bus.i_data_valid;
                        bus.o_data_ready  <= (next_idx + 16'd1) < NBYTES;
                    end
                end
                S_CRC: begin
                    if (stop) begin
                        st                <= S_END;
                        aborted           <= 1'b1;
                        bus.o_sd_data_out <= 8'hFF;
                    end else if (cnt[2:0] == 3'd7) begin
                        st                <= S_END;
                        remaining         <= remaining - 16'd1;
                        bus.o_block_sent  <= 1'b1;
                        bus.o_sd_data_out <= 8'hFF;
                    end else begin
                        cnt               <= cnt + 16'd1;
                        bus.o_sd_data_out <= crc_out(crc, cnt[2:0] + 3'd1);
                    end
                end
                S_END: begin
                    cnt <= '0;
                    st  <= (aborted || remaining == '0) ? S_TURN : S_GAP;
                end
                S_GAP: begin
                    if (stop) begin
                        st  <= S_TURN;
                        cnt <= '0;
                    end else if (cnt == LAST_GAP) begin
                        st                <= S_START;
                        crc               <= '0;
                        bus.o_sd_data_out <= 8'hF0;
                        bus.o_data_ready  <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_TURN: begin
                    if (cnt == LAST_TURN) begin
                        st                <= S_IDLE;
                        bus.o_sd_data_dir <= 1'b0;
                        bus.o_busy        <= 1'b0;
                        bus.o_done        <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule
